aes_out_serializer: RTL and testbench
=====================================

// Module: aes_out_serializer
// PURPOSE
//  Downstream stage of the AES round engine. Captures each finished 128-bit ciphertext
//  block (ENC) on a one-cycle done strobe. Holds up to two blocks in a ping-pong buffer.
//  Streams them out as WORD_W-bit words over a valid/ready handshake, so the engine can
//  start the next block while the previous one drains.
// PARAMETERS
//  WORD_W   32   output word width; must divide 128 (legal: 8, 16, 32, 64)
//  NWORDS   128/WORD_W   words per block (derived, do not override)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset      in   1       asynchronous, active-low reset
//  enc_data   in   128     ciphertext block from the round engine
//  enc_valid  in   1       one-cycle strobe: enc_data is a finished block
//  enc_ready  out  1       a buffer slot is free (registered-state function only)
//  out_data   out  WORD_W  current output word
//  out_valid  out  1       out_data valid
//  out_ready  in   1       consumer accepts word (handshake = out_valid & out_ready)
//  out_last   out  1       out_data is the final word of its block
//  blk_cnt    out  8       blocks fully emitted, wraps 255->0
//  ovf        out  1       sticky: a block arrived while both slots were full
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (reset=0, any time, incl. mid-block): occupancy=0, word index=0, head/tail=slot0,
//   out_valid=0, out_last=0, out_data=0, blk_cnt=0, ovf=0, enc_ready=1.
//   Partially sent block is discarded.
//  Storage: slot[0..1] x 128b; occ (0..2), head, tail, widx (0..NWORDS-1) registers.
//  enc_ready = (occ != 2), decoded from registers only; never depends on enc_valid.
//  Capture: enc_valid & enc_ready -> slot[tail] <= enc_data, tail toggles, occ+1.
//  Drop: enc_valid & !enc_ready -> block discarded, ovf <= 1 (cleared only by reset).
//   A drop happens even if the head block completes in the same cycle.
//  State machine (2 states):
//   IDLE: out_valid=0. When occ>0 (registered) -> SEND with widx=0.
//   SEND: out_valid=1. out_data = slot[head] word widx, MSW first:
//    widx 0 = bits[127:128-WORD_W].
//    out_last = (widx == NWORDS-1).
//    Handshake on non-last word: widx+1.
//    Handshake on last word: widx=0, head toggles, occ-1, blk_cnt+1.
//     Stay in SEND if another block remains, else go to IDLE.
//  Simultaneous capture + last-word handshake: occ unchanged, both slot updates apply.
//  Latency: capture at edge N (into empty buffer) -> out_valid=1 with word 0 after edge N+1.
//   Back-to-back blocks stream with no idle cycle between last word and next word 0.
//  Stability: while out_valid & !out_ready, out_data/out_last hold constant.
//  out_valid never deasserts without a handshake.
//  out_data is driven from registered slot/index; no combinational path from enc_* to out_*.
// TESTING
//  1 Reset: reset=0 mid-SEND -> out_valid=0, blk_cnt=0, ovf=0, enc_ready=1 immediately.
//  2 Single block: enc_data=128'h00112233_44556677_8899aabb_ccddeeff, out_ready=1.
//     Expect words 00112233, 44556677, 8899aabb, ccddeeff.
//     out_last on 4th word, blk_cnt=1, then IDLE.
//  3 Backpressure: out_ready toggled 1,0,0,1,... -> each word held stable while stalled,
//     sequence unchanged, no duplicates.
//  4 Two blocks back-to-back, out_ready=0 -> enc_ready=0 after 2nd capture.
//     Release -> 8 contiguous words, 2 out_last pulses, blk_cnt=2.
//  5 Overflow: 3 captures with out_ready=0 -> 3rd dropped, ovf=1 sticky.
//     Output carries only blocks 1 and 2.
//  6 Simultaneous: occ=1, enc_valid on same cycle as last-word handshake.
//     Expect occ stays 1, next block word 0 follows immediately.
//     Plus 256-block run: blk_cnt wraps to 0.

Source files
------------

// File: rtl/aes_out_serializer.sv
// AES ciphertext output serializer: two-slot ping-pong buffer that drains each
// 128-bit block as NWORDS words, most-significant word first, over valid/ready.
module aes_out_serializer #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [127:0]      enc_data,
   input  logic              enc_valid,
   output logic              enc_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [7:0]        blk_cnt,
   output logic              ovf
);

   localparam int NWORDS = 128 / WORD_W;
   localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NWORDS - 1);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t              state_q, state_d;
   logic [127:0]        slot_q [2];
   logic [127:0]        slot_d [2];
   logic [1:0]          occ_q, occ_d;
   logic                head_q, head_d;
   logic                tail_q, tail_d;
   logic [WIDX_W-1:0]   widx_q, widx_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic                cap;
   logic                hs;
   logic                last_hs;
   logic                more;
   logic [127:0]        next_blk;
   logic [WIDX_W-1:0]   widx_inc;

   function automatic logic [WORD_W-1:0] word_of(input logic [127:0] blk,
                                                 input logic [WIDX_W-1:0] idx);
      logic [127:0] sh;
      sh = blk << (32'(idx) * WORD_W);
      return sh[127 -: WORD_W];
   endfunction

   always_comb begin
      cap      = enc_valid && (occ_q != 2'd2);
      hs       = valid_q && out_ready;
      last_hs  = hs && last_q;
      widx_inc = widx_q + 1'b1;
      // With one block left, the only follow-on block is the one landing this
      // cycle, so word 0 is taken straight from enc_data to avoid a bubble.
      next_blk = (occ_q == 2'd2) ? slot_q[~head_q] : enc_data;
      more     = (occ_q == 2'd2) || cap;

      slot_d[0] = slot_q[0];
      slot_d[1] = slot_q[1];
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      widx_d    = widx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;

      if (cap) begin
         slot_d[tail_q] = enc_data;
         tail_d         = ~tail_q;
      end
      if (enc_valid && !cap) begin
         ovf_d = 1'b1;
      end
      occ_d = occ_q + {1'b0, cap} - {1'b0, last_hs};

      case (state_q)
         S_IDLE: begin
            if (occ_q != 2'd0) begin
               state_d = S_SEND;
               widx_d  = '0;
               valid_d = 1'b1;
               data_d  = word_of(slot_q[head_q], '0);
               last_d  = (LAST_IDX == WIDX_W'(0));
            end
         end
         S_SEND: begin
            if (last_hs) begin
               widx_d = '0;
               head_d = ~head_q;
               cnt_d  = cnt_q + 1'b1;
               if (more) begin
                  data_d = word_of(next_blk, '0);
                  last_d = (LAST_IDX == WIDX_W'(0));
               end else begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end
            end else if (hs) begin
               widx_d = widx_inc;
               data_d = word_of(slot_q[head_q], widx_inc);
               last_d = (widx_inc == LAST_IDX);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         occ_q     <= '0;
         head_q    <= 1'b0;
         tail_q    <= 1'b0;
         widx_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q[0] <= slot_d[0];
         slot_q[1] <= slot_d[1];
         occ_q     <= occ_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         widx_q    <= widx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign enc_ready = (occ_q != 2'd2);
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign blk_cnt   = cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Bench for aes_out_serializer: directed scenarios plus a randomized run against
// a queue-based model of accepted blocks and emitted words.
module tb_aes_out_serializer;

   localparam int W  = 32;
   localparam int NW = 128 / W;

   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  enc_data;
   logic          enc_valid;
   logic          enc_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [7:0]    blk_cnt;
   logic          ovf;

   always #5 clk = ~clk;

   aes_out_serializer #(.WORD_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .enc_data  (enc_data),
      .enc_valid (enc_valid),
      .enc_ready (enc_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .blk_cnt   (blk_cnt),
      .ovf       (ovf)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Model: blocks accepted but not fully emitted, position in the head block.
   logic [127:0] pend [$];
   int           widx_m;
   int           done_m;
   bit           ovf_m;
   bit           expv;

   function automatic logic [W-1:0] mword(input logic [127:0] b, input int i);
      logic [127:0] s;
      s = b >> (128 - (i + 1) * W);
      return s[W-1:0];
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      pend.delete();
      widx_m = 0;
      done_m = 0;
      ovf_m  = 1'b0;
      expv   = 1'b0;
   endtask

   // Drive inputs at a falling edge, advance one rising edge, update the model.
   task automatic step(input bit v, input logic [127:0] d, input bit r);
      int occ0;
      bit hs, lhs;
      enc_valid = v;
      enc_data  = d;
      out_ready = r;
      @(posedge clk);
      occ0 = pend.size();
      hs   = expv && r;
      lhs  = 1'b0;
      if (hs) begin
         widx_m++;
         if (widx_m == NW) begin
            widx_m = 0;
            void'(pend.pop_front());
            done_m++;
            lhs = 1'b1;
         end
      end
      if (v) begin
         if (occ0 < 2) pend.push_back(d);
         else ovf_m = 1'b1;
      end
      if (!expv) expv = (occ0 > 0);
      else if (lhs) expv = (pend.size() > 0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; enc_valid = 1'b0; enc_data = '0; out_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
          blk_cnt !== 8'd0 || ovf !== 1'b0 || enc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b l=%b d=%h cnt=%0d ovf=%b rdy=%b want 0,0,0,0,0,1",
                  out_valid, out_last, out_data, blk_cnt, ovf, enc_ready);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      logic [127:0] blk;
      logic [W-1:0] want [4];
      logic [W-1:0] got [4];
      bit           lst [4];
      int           n;
      blk = 128'h00112233_44556677_8899aabb_ccddeeff;
      want[0] = 32'h00112233; want[1] = 32'h44556677;
      want[2] = 32'h8899aabb; want[3] = 32'hccddeeff;
      step(1'b1, blk, 1'b1);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_latency_edgeN: out_valid=%b want 0", out_valid);
      end
      step(1'b0, rnd128(), 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== want[0]) begin
         miscompares++;
         $display("FAIL single_latency_edgeN1: v=%b d=%h want 1 %h", out_valid, out_data, want[0]);
      end
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         if (out_valid) begin
            got[n] = out_data;
            lst[n] = out_last;
            n++;
         end
         step(1'b0, rnd128(), 1'b1);
      end
      vectors++;
      if (n != 4) begin
         miscompares++;
         $display("FAIL single_timeout: got %0d words want 4", n);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== want[i] || lst[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL single_word%0d: got %h last=%b want %h last=%b",
                        i, got[i], lst[i], want[i], (i == 3));
            end
         end
      end
      vectors++;
      if (out_valid !== 1'b0 || blk_cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL single_end: v=%b cnt=%0d want 0 1", out_valid, blk_cnt);
      end
   endtask

   task automatic test_backpressure();
      bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit           stalled, r;
      logic [W-1:0] prevd;
      logic         prevl;
      int           d0;
      d0 = done_m;
      stalled = 1'b0; prevd = '0; prevl = 1'b0;
      step(1'b1, rnd128(), 1'b0);
      for (int c = 0; c < 60 && done_m == d0; c++) begin
         vectors++;
         if (out_valid !== expv) begin
            miscompares++;
            $display("FAIL bp_valid: got %b want %b", out_valid, expv);
         end
         if (expv && pend.size() > 0) begin
            vectors++;
            if (out_data !== mword(pend[0], widx_m) || out_last !== (widx_m == NW - 1)) begin
               miscompares++;
               $display("FAIL bp_word%0d: got %h last=%b want %h last=%b", widx_m,
                        out_data, out_last, mword(pend[0], widx_m), (widx_m == NW - 1));
            end
         end
         if (stalled) begin
            vectors++;
            if (out_data !== prevd || out_last !== prevl) begin
               miscompares++;
               $display("FAIL bp_hold: got %h/%b want %h/%b", out_data, out_last, prevd, prevl);
            end
         end
         r = pat[c % 4];
         stalled = out_valid && !r;
         prevd = out_data;
         prevl = out_last;
         step(1'b0, rnd128(), r);
      end
      vectors++;
      if (done_m == d0) begin
         miscompares++;
         $display("FAIL bp_timeout: blocks done %0d want %0d", done_m, d0 + 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] a, b;
      logic [W-1:0] exp;
      int           lastcnt, d0;
      a = rnd128(); b = rnd128();
      d0 = done_m;
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      vectors++;
      if (enc_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_full: enc_ready=%b want 0", enc_ready);
      end
      step(1'b0, rnd128(), 1'b0);
      lastcnt = 0;
      for (int k = 0; k < 2 * NW; k++) begin
         exp = (k < NW) ? mword(a, k) : mword(b, k - NW);
         vectors++;
         if (out_valid !== 1'b1 || out_data !== exp) begin
            miscompares++;
            $display("FAIL b2b_word%0d: v=%b d=%h want 1 %h", k, out_valid, out_data, exp);
         end
         if (out_last === 1'b1) lastcnt++;
         step(1'b0, rnd128(), 1'b1);
      end
      vectors++;
      if (out_valid !== 1'b0 || lastcnt != 2 || blk_cnt !== 8'(d0 + 2)) begin
         miscompares++;
         $display("FAIL b2b_end: v=%b lasts=%0d cnt=%0d want 0 2 %0d",
                  out_valid, lastcnt, blk_cnt, d0 + 2);
      end
   endtask

   task automatic test_overflow();
      logic [127:0] a, b;
      logic [W-1:0] got [2*NW];
      int           n, extra;
      a = rnd128(); b = rnd128();
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b1, rnd128(), 1'b0);
      vectors++;
      if (ovf !== 1'b1 || enc_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_set: ovf=%b rdy=%b want 1 0", ovf, enc_ready);
      end
      n = 0; extra = 0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid) begin
            if (n < 2 * NW) got[n] = out_data;
            else extra++;
            n++;
         end
         step(1'b0, rnd128(), 1'b1);
      end
      vectors++;
      if (n != 2 * NW || extra != 0) begin
         miscompares++;
         $display("FAIL ovf_count: got %0d words want %0d", n, 2 * NW);
      end else begin
         for (int k = 0; k < 2 * NW; k++) begin
            vectors++;
            if (got[k] !== ((k < NW) ? mword(a, k) : mword(b, k - NW))) begin
               miscompares++;
               $display("FAIL ovf_word%0d: got %h want %h", k, got[k],
                        (k < NW) ? mword(a, k) : mword(b, k - NW));
            end
         end
      end
      vectors++;
      if (ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: ovf=%b want 1", ovf);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, rnd128(), 1'b0);
      step(1'b1, rnd128(), 1'b0);
      step(1'b1, rnd128(), 1'b0);
      step(1'b0, rnd128(), 1'b1);
      step(1'b0, rnd128(), 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || ovf !== 1'b1 || blk_cnt === 8'd0) begin
         miscompares++;
         $display("FAIL rstmid_pre: v=%b ovf=%b cnt=%0d want 1 1 nonzero", out_valid, ovf, blk_cnt);
      end
      enc_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
          blk_cnt !== 8'd0 || ovf !== 1'b0 || enc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_async: v=%b l=%b d=%h cnt=%0d ovf=%b rdy=%b want 0,0,0,0,0,1",
                  out_valid, out_last, out_data, blk_cnt, ovf, enc_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      step(1'b0, rnd128(), 1'b1);
      step(1'b0, rnd128(), 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || enc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_discard: v=%b rdy=%b want 0 1", out_valid, enc_ready);
      end
   endtask

   task automatic test_simultaneous();
      logic [127:0] a, b;
      int           d0, c;
      a = rnd128(); b = rnd128();
      d0 = done_m;
      step(1'b1, a, 1'b1);
      step(1'b0, rnd128(), 1'b1);
      c = 0;
      while (!(out_valid && out_last) && c < 10) begin
         step(1'b0, rnd128(), 1'b1);
         c++;
      end
      vectors++;
      if (!(out_valid && out_last)) begin
         miscompares++;
         $display("FAIL simul_timeout: no last word within 10 cycles");
      end
      step(1'b1, b, 1'b1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== mword(b, 0) || out_last !== 1'b0 ||
          enc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_next: v=%b d=%h l=%b rdy=%b want 1 %h 0 1",
                  out_valid, out_data, out_last, enc_ready, mword(b, 0));
      end
      c = 0;
      while (out_valid && c < 10) begin
         step(1'b0, rnd128(), 1'b1);
         c++;
      end
      vectors++;
      if (out_valid !== 1'b0 || blk_cnt !== 8'(d0 + 2)) begin
         miscompares++;
         $display("FAIL simul_end: v=%b cnt=%0d want 0 %0d", out_valid, blk_cnt, d0 + 2);
      end
   endtask

   task automatic test_random();
      bit v, r;
      for (int c = 0; c < 800; c++) begin
         vectors++;
         if (out_valid !== expv || enc_ready !== (pend.size() < 2) ||
             blk_cnt !== 8'(done_m) || ovf !== ovf_m) begin
            miscompares++;
            $display("FAIL rand_ctrl c=%0d: v=%b rdy=%b cnt=%0d ovf=%b want %b %b %0d %b", c,
                     out_valid, enc_ready, blk_cnt, ovf, expv, (pend.size() < 2), 8'(done_m), ovf_m);
         end
         if (expv && pend.size() > 0) begin
            vectors++;
            if (out_data !== mword(pend[0], widx_m) || out_last !== (widx_m == NW - 1)) begin
               miscompares++;
               $display("FAIL rand_word c=%0d: got %h last=%b want %h last=%b", c,
                        out_data, out_last, mword(pend[0], widx_m), (widx_m == NW - 1));
            end
         end
         if (c < 400) begin
            v = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end else begin
            v = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 2) == 0);
         end
         step(v, rnd128(), r);
      end
   endtask

   task automatic test_wrap();
      int acc;
      bit saw255;
      enc_valid = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      acc = 0;
      saw255 = 1'b0;
      for (int c = 0; c < 3000 && done_m < 256; c++) begin
         if (acc < 256 && pend.size() < 2) begin
            acc++;
            step(1'b1, rnd128(), 1'b1);
         end else begin
            step(1'b0, rnd128(), 1'b1);
         end
         vectors++;
         if (blk_cnt !== 8'(done_m)) begin
            miscompares++;
            $display("FAIL wrap_cnt: got %0d want %0d", blk_cnt, 8'(done_m));
         end
         if (blk_cnt === 8'd255) saw255 = 1'b1;
      end
      vectors++;
      if (done_m != 256 || blk_cnt !== 8'd0 || !saw255 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_end: done=%0d cnt=%0d saw255=%b v=%b want 256 0 1 0",
                  done_m, blk_cnt, saw255, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_simultaneous();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
